conv_mac_unit: RTL and testbench

CONV_MAC_UNIT -- requirements
Module: conv_mac_unit

---
 rtl/conv_mac_unit.sv | 120 ++++++++++++
 tb/tb_conv_mac_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_unit.sv
// conv_mac_unit: saturating fixed-point dot product of an image patch and a filter, LANES products per beat.
// Define CONV_MAC_BIAS_EN to add a bias input that is preloaded into the accumulator.
module conv_mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int D          = 1,
  parameter int F          = 3,
  parameter int LANES      = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D*F*F*DATA_WIDTH-1:0]  image,
  input  logic [D*F*F*DATA_WIDTH-1:0]  filter,
`ifdef CONV_MAC_BIAS_EN
  input  logic signed [DATA_WIDTH-1:0] bias,
`endif
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        result,
  output logic                         sat
);
  localparam int N     = D*F*F;
  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam int PW    = 2*DATA_WIDTH;
  localparam int ACC_W = PW + $clog2(N);
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;

  logic signed [DATA_WIDTH-1:0] r_img [N];
  logic signed [DATA_WIDTH-1:0] r_flt [N];
  logic signed [DATA_WIDTH-1:0] w_a, w_b;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_W-1:0]      r_acc, r_psum, w_psum, w_preload, w_shift;
  logic [BW-1:0]                r_beat;
  logic [DATA_WIDTH-1:0]        r_result;
  logic                         r_sat, w_accept, w_hi, w_lo;

`ifdef CONV_MAC_BIAS_EN
  assign w_preload = ACC_W'(bias) <<< FRAC_BITS;
`else
  assign w_preload = '0;
`endif

  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_accept  = in_valid && in_ready;
  assign result    = r_result;
  assign sat       = r_sat;
  assign w_shift   = r_acc >>> FRAC_BITS;
  assign w_hi      = w_shift > MAXV;
  assign w_lo      = w_shift < MINV;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  // RUN lasts one cycle past the last issue so the final lane sum lands in the accumulator
  always_comb begin
    w_next = r_state;
    w_next = (r_state != IDLE && abort)               ? IDLE  :
             (r_state == IDLE && in_valid)            ? RUN   :
             (r_state == RUN && r_beat == BW'(BEATS)) ? DRAIN :
             (r_state == DRAIN)                       ? DONE  :
             (r_state == DONE && out_ready)           ? IDLE  : r_state;
  end

  // one multiplier per lane, fed by a per-beat operand mux; lanes past N read zero
  always_comb begin
    w_psum = '0;
    w_a    = '0;
    w_b    = '0;
    w_prod = '0;
    for (int l = 0; l < LANES; l++) begin
      w_a = '0;
      w_b = '0;
      for (int b = 0; b < BEATS; b++)
        if (b*LANES + l < N && r_beat == BW'(b)) begin
          w_a = r_img[(b*LANES + l < N) ? b*LANES + l : 0];
          w_b = r_flt[(b*LANES + l < N) ? b*LANES + l : 0];
        end
      w_prod = PW'(w_a) * PW'(w_b);
      w_psum = w_psum + ACC_W'(w_prod);
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int e = 0; e < N; e++) begin
        r_img[e] <= '0;
        r_flt[e] <= '0;
      end
      r_acc    <= '0;
      r_psum   <= '0;
      r_beat   <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else if (w_accept) begin
      for (int e = 0; e < N; e++) begin
        r_img[e] <= image[(N-1-e)*DATA_WIDTH +: DATA_WIDTH];
        r_flt[e] <= filter[(N-1-e)*DATA_WIDTH +: DATA_WIDTH];
      end
      r_acc  <= w_preload;
      r_psum <= '0;
      r_beat <= '0;
    end else if (r_state == RUN) begin
      r_psum <= (r_beat < BW'(BEATS)) ? w_psum : '0;
      r_acc  <= r_acc + r_psum;
      r_beat <= (r_beat < BW'(BEATS)) ? r_beat + BW'(1) : r_beat;
    end else if (r_state == DRAIN) begin
      r_result <= w_hi ? MAXV[DATA_WIDTH-1:0] : w_lo ? MINV[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
      r_sat    <= w_hi || w_lo;
    end
endmodule

// File: tb/tb_conv_mac_unit.sv
// tb_conv_mac_unit: directed bench for conv_mac_unit at LANES=1 and LANES=4 against a transaction-level model.
module tb_conv_mac_unit;
  localparam int N  = 9;
  localparam int DW = 16;
  localparam int LN [2] = '{1, 4};

  logic              clk = 0, reset_n = 0, in_valid = 0, abort = 0, out_ready = 1;
  logic [N*DW-1:0]   image = '0, filter = '0;
  logic signed [DW-1:0] bias_v = '0;
  logic [1:0]        ir, ov, st;
  logic [2*DW-1:0]   rs;
  int                n_cmp = 0, n_err = 0;

  bit                act [2];
  int                cnt [2];
  logic [DW:0]       ex  [2];

  always #5 clk = ~clk;

  conv_mac_unit #(.LANES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
    .image(image), .filter(filter),
`ifdef CONV_MAC_BIAS_EN
    .bias(bias_v),
`endif
    .abort(abort), .out_valid(ov[0]), .out_ready(out_ready),
    .result(rs[DW-1:0]), .sat(st[0]));

  conv_mac_unit #(.LANES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
    .image(image), .filter(filter),
`ifdef CONV_MAC_BIAS_EN
    .bias(bias_v),
`endif
    .abort(abort), .out_valid(ov[1]), .out_ready(out_ready),
    .result(rs[2*DW-1:DW]), .sat(st[1]));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic int lat_of(input int k);
    return (N + LN[k] - 1) / LN[k] + 2;
  endfunction

  // exact dot product plus bias, floor-shifted and clamped: {sat, result}
  function automatic logic [DW:0] model(input logic [N*DW-1:0] im, input logic [N*DW-1:0] fl,
                                        input logic signed [DW-1:0] b);
    longint acc;
    acc = longint'(b) * 256;
    for (int e = 0; e < N; e++)
      acc += longint'($signed(im[e*DW +: DW])) * longint'($signed(fl[e*DW +: DW]));
    acc = acc >>> 8;
    if (acc > 32767) return {1'b1, 16'h7FFF};
    if (acc < -32768) return {1'b1, 16'h8000};
    return {1'b0, acc[DW-1:0]};
  endfunction

  always @(posedge clk or negedge reset_n)
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        act[k] <= 0;
        cnt[k] <= 0;
      end else if (!act[k]) begin
        if (in_valid) begin
          act[k] <= 1;
          cnt[k] <= 0;
          ex[k]  <= model(image, filter, bias_v);
        end
      end else if (abort || (cnt[k] >= lat_of(k) && out_ready)) act[k] <= 0;
      else if (cnt[k] < lat_of(k)) cnt[k] <= cnt[k] + 1;
    end

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready%0d", k), 32'(ir[k]), 32'(!act[k]));
      chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(act[k] && cnt[k] >= lat_of(k)));
      if (act[k] && cnt[k] >= lat_of(k)) begin
        chk($sformatf("result%0d", k), 32'(rs[k*DW +: DW]), 32'(ex[k][DW-1:0]));
        chk($sformatf("sat%0d", k), 32'(st[k]), 32'(ex[k][DW]));
      end
    end

  task automatic op(input logic [DW-1:0] iv, input logic [DW-1:0] fv,
                    input logic [DW-1:0] er, input logic es, input string nm);
    int l0, l1;
    logic [DW-1:0] r0;
    logic s0;
    l0 = -1; l1 = -1; r0 = '0; s0 = 0;
    image = {N{iv}}; filter = {N{fv}}; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; image = ~image; filter = ~filter;
    for (int c = 1; c <= 30 && (l0 < 0 || l1 < 0); c++) begin
      @(posedge clk); #1;
      if (ov[0] && l0 < 0) begin l0 = c; r0 = rs[DW-1:0]; s0 = st[0]; end
      if (ov[1] && l1 < 0) l1 = c;
    end
    chk({nm, " lat1"}, 32'(l0), 32'd11);
    chk({nm, " lat4"}, 32'(l1), 32'd5);
    chk({nm, " result"}, 32'(r0), 32'(er));
    chk({nm, " sat"}, 32'(s0), 32'(es));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    chk("model unit", 32'(model({N{16'h0100}}, {N{16'h0100}}, 16'sh0)), 32'h0900);
    chk("model neg", 32'(model({N{16'hFF00}}, {N{16'h0100}}, 16'sh0)), 32'h0F700);
    chk("model satn", 32'(model({N{16'h7FFF}}, {N{16'h8000}}, 16'sh0)), 32'h18000);
    #2;
    chk("rst out_valid", 32'(ov), 32'd0);
    chk("rst result", 32'(rs), 32'd0);
    chk("rst sat", 32'(st), 32'd0);
    #21 reset_n = 1;
    @(posedge clk); #1;
    chk("rst in_ready", 32'(ir), 32'd3);
    op(16'h0100, 16'h0100, 16'h0900, 1'b0, "unit");
    op(16'hFF00, 16'h0100, 16'hF700, 1'b0, "neg");
    op(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "satp");
    op(16'h7FFF, 16'h8000, 16'h8000, 1'b1, "satn");
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("idle abort in_ready", 32'(ir), 32'd3);
    out_ready = 0;
    image = {N{16'h0100}}; filter = {N{16'h0100}}; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (int c = 0; c < 30 && !ov[0]; c++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; image = {N{16'h7FFF}};
      @(posedge clk); #1;
      chk("hold out_valid", 32'(ov), 32'd3);
      chk("hold result", 32'(rs), {16'h0900, 16'h0900});
      chk("hold in_ready", 32'(ir), 32'd0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("release out_valid", 32'(ov), 32'd0);
    chk("release in_ready", 32'(ir), 32'd3);
    image = {N{16'h0100}}; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1;
    abort = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov != 0) seen++;
    end
    chk("abort no valid", 32'(seen), 32'd0);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    reset_n = 0;
    #3 chk("midrst result", 32'(rs), 32'd0);
    reset_n = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov != 0) seen++;
    end
    chk("reset no valid", 32'(seen), 32'd0);
    op(16'h0100, 16'h0100, 16'h0900, 1'b0, "after");
`ifdef CONV_MAC_BIAS_EN
    bias_v = 16'shFF00;
    op(16'h0100, 16'h0100, 16'h0800, 1'b0, "bias");
    bias_v = '0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
